// File: rtl/edge_det_pkg.sv
// Shared constants and types for the edge detector slice.
package edge_det_pkg;

    // Synchronizer depth: default and the legal range.
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Per-cycle edge decode of the synchronized level.
    typedef struct packed {
        logic rise;
        logic fall;
        logic both;
    } edge_t;

    // True when a synchronizer depth is one the design supports.
    function automatic bit sync_stages_legal(input int stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/edge_det_sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the input through the chain; bit 0 is the metastability catcher.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/edge_det.sv
// Edge detector: synchronizes dat_i, compares against the previous
// synchronized sample and emits registered one-cycle edge pulses.
module edge_det
    import edge_det_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic dat_i,
    output logic edge_rising,
    output logic edge_falling,
    output logic edge_both
);

    // Refuse to elaborate with an unsupported synchronizer depth.
    generate
        if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
            $error("edge_det: SYNC_STAGES=%0d outside %0d..%0d",
                   SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
        end
    endgenerate

    logic  sync_q;
    logic  prev_q;
    edge_t det;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (dat_i),
        .q    (sync_q)
    );

    // History flop: the synchronized level one cycle ago.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= sync_q;
        end
    end

    // Edge decode between the current and previous synchronized samples.
    always_comb begin
        det      = '0;
        det.rise = sync_q & ~prev_q;
        det.fall = ~sync_q & prev_q;
        det.both = sync_q ^ prev_q;
    end

    // Output register: keeps dat_i off any combinational path to the ports.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_rising  <= 1'b0;
            edge_falling <= 1'b0;
            edge_both    <= 1'b0;
        end else begin
            edge_rising  <= det.rise;
            edge_falling <= det.fall;
            edge_both    <= det.both;
        end
    end

endmodule

// File: tb/tb_edge_det.sv
// Directed bench for edge_det with SYNC_STAGES=2, plus a randomized
// fast-toggling input checked against a sample-history reference.
`timescale 1ns/1ps
module tb_edge_det;

    logic clk;
    logic rstn;
    logic dat_i;
    logic edge_rising;
    logic edge_falling;
    logic edge_both;

    int n_cmp;
    int n_bad;

    edge_det #(
        .SYNC_STAGES (2),
        .RST_VAL     (1'b0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .dat_i        (dat_i),
        .edge_rising  (edge_rising),
        .edge_falling (edge_falling),
        .edge_both    (edge_both)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [2:0] obs;
        rstn  = 1'b1;
        dat_i = 1'b0;
        #1 rstn = 1'b0;
        #1;
        obs = {edge_rising, edge_falling, edge_both};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_async got=%b exp=000", obs);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            dat_i = 1'($urandom_range(0, 1));
            obs = {edge_rising, edge_falling, edge_both};
            n_cmp++;
            if (obs !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_hold[%0d] got=%b exp=000", i, obs);
            end
        end
        step();
        dat_i = 1'b0;
        rstn  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            obs = {edge_rising, edge_falling, edge_both};
            n_cmp++;
            if (obs !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_release_quiet[%0d] got=%b exp=000", i, obs);
            end
        end
    endtask

    // Level already settled at 0; drive 1 and hold.
    task automatic test_single_rise;
        logic [2:0] obs;
        logic [2:0] exp;
        step();
        dat_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = (i == 3) ? 3'b101 : 3'b000;
            obs = {edge_rising, edge_falling, edge_both};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_rise[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // Level settled at 1; drive 0 and hold.
    task automatic test_single_fall;
        logic [2:0] obs;
        logic [2:0] exp;
        step();
        dat_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = (i == 3) ? 3'b011 : 3'b000;
            obs = {edge_rising, edge_falling, edge_both};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_fall[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // Toggle on every clk sample for 16 samples, starting from 0.
    task automatic test_toggle;
        logic [2:0] obs;
        logic [2:0] exp;
        int n_rise;
        int n_fall;
        n_rise = 0;
        n_fall = 0;
        step();
        for (int n = 0; n < 22; n++) begin
            if (n >= 3 && n < 19) begin
                exp = ((n - 3) % 2 == 0) ? 3'b101 : 3'b011;
            end else begin
                exp = 3'b000;
            end
            obs = {edge_rising, edge_falling, edge_both};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL toggle[%0d] got=%b exp=%b", n, obs, exp);
            end
            if (edge_rising === 1'b1) n_rise++;
            if (edge_falling === 1'b1) n_fall++;
            if (n < 16) dat_i = ~dat_i;
            step();
        end
        n_cmp++;
        if (n_rise != 8 || n_fall != 8) begin
            n_bad++;
            $display("FAIL toggle_counts got=%0d/%0d exp=8/8", n_rise, n_fall);
        end
    endtask

    // Reset hits while a rising pulse is on the outputs; dat_i stays 1.
    task automatic test_reset_mid_pulse;
        logic [2:0] obs;
        logic [2:0] exp;
        dat_i = 1'b1;
        step();
        step();
        step();
        obs = {edge_rising, edge_falling, edge_both};
        n_cmp++;
        if (obs !== 3'b101) begin
            n_bad++;
            $display("FAIL midpulse_pre got=%b exp=101", obs);
        end
        #1 rstn = 1'b0;
        #1;
        obs = {edge_rising, edge_falling, edge_both};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_bad++;
            $display("FAIL midpulse_cleared got=%b exp=000", obs);
        end
        step();
        step();
        rstn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = (i == 3) ? 3'b101 : 3'b000;
            obs = {edge_rising, edge_falling, edge_both};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL midpulse_release[%0d] got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    // Random level changing every half clk period, away from clk edges.
    task automatic test_random;
        logic h0, h1, h2, h3;
        logic [2:0] obs;
        logic [2:0] exp;
        h0 = dat_i;
        h1 = dat_i;
        h2 = dat_i;
        h3 = dat_i;
        fork
            begin
                #2.5;
                repeat (4000) begin
                    dat_i = 1'($urandom_range(0, 1));
                    #5;
                end
            end
            begin
                for (int c = 0; c < 2000; c++) begin
                    @(posedge clk);
                    h3 = h2;
                    h2 = h1;
                    h1 = h0;
                    h0 = dat_i;
                    #1;
                    exp = {h2 & ~h3, ~h2 & h3, h2 ^ h3};
                    obs = {edge_rising, edge_falling, edge_both};
                    n_cmp++;
                    if (obs !== exp) begin
                        n_bad++;
                        $display("FAIL random[%0d] got=%b exp=%b", c, obs, exp);
                    end
                    n_cmp++;
                    if (edge_rising === 1'b1 && edge_falling === 1'b1) begin
                        n_bad++;
                        $display("FAIL random_exclusive[%0d] got=11 exp=not both", c);
                    end
                end
            end
        join
        step();
        dat_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b1;
        dat_i = 1'b0;
        test_reset();
        test_single_rise();
        test_single_fall();
        test_toggle();
        test_reset_mid_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
